busy_initiator: RTL and testbench
=================================

Name: busy_initiator

Overview:
Initiator side of the start/busy handshake used by the team's fixed-duration busy counters. Queues job requests from upstream and issues one-cycle start pulses to a busy-counter peer, then tracks the peer's busy line to completion. Flags protocol faults: no busy acknowledgement, busy stuck high, and spurious busy. Sits between control logic and any counter-style peripheral exposing start/busy.

Parameters:
MAX_PENDING, 3, max queued (not yet dispatched) requests; 1..15
ACK_WAIT, 2, cycles after o_start within which i_busy must rise; >=1
MAX_WAIT, 32, max cycles i_busy may stay high per job; 16-bit, >=2

Ports:
i_clk  in  1  clock, all logic posedge
i_reset_n  in  1  synchronous active-low reset
i_req  in  1  request one job; accepted when i_req && o_req_ready
o_req_ready  out  1  pending < MAX_PENDING
o_start  out  1  one-cycle registered start pulse to peer start input
i_busy  in  1  peer busy line
o_done  out  1  one-cycle pulse, job completed
o_err  out  1  one-cycle pulse, fault detected
o_err_code  out  2  valid with o_err: 01 no-ack, 10 stuck-busy, 11 spurious-busy
o_pending  out  4  queued request count

Behaviour:
- Reset (i_reset_n=0 at posedge): state IDLE, pending=0, timers 0, o_start/o_done/o_err=0, o_err_code=00. Reset mid-job drops all queued work; outputs clean from the cycle after reset.
- Pending: next = pending + accept - dispatch; simultaneous accept and dispatch leaves it unchanged. Never over- or underflows.
- IDLE: if (pending>0 || accept) && !i_busy: o_start<=1, dispatch, go ACK. A request accepted in cycle N gives o_start high in cycle N+1.
- IDLE with i_busy=1: o_err pulse, code 11, once per busy episode (re-arms when i_busy falls). Starts are blocked while i_busy=1.
- ACK: o_start low. Load timer with ACK_WAIT. i_busy=1 → RUN. Timer expiry with no busy → o_err code 01, job dropped, back to IDLE.
- RUN: count busy cycles.
  - i_busy=0 → o_done pulse next cycle, go IDLE.
  - Count reaches MAX_WAIT → o_err code 10 (once), go DRAIN.
- DRAIN: no starts; wait for i_busy=0 with no timeout, then go IDLE. No o_done for the faulted job.
- o_done and o_err are never asserted in the same cycle.
- At most one o_start per job. o_start is never asserted in two consecutive cycles.
- Start-to-start spacing with a MAX_AMOUNT=M peer: M+2 cycles.

Optional Feature:
BUSY_INITIATOR_STATS_EN
- Defined: adds 16-bit saturating counters o_done_cnt and o_err_cnt, cleared by reset. Each increments on its pulse and holds at 0xFFFF.
- Undefined: both ports exist, are tied to 0, and no counters are synthesised.

Decomposition:
- Shared include busy_defs.vh: state encodings (IDLE/ACK/RUN/DRAIN) and err code localparams (ERR_NONE/ERR_NOACK/ERR_STUCK/ERR_SPUR). The busy counter testbench reuses the same file.
- Sub-module busy_wait_timer: loadable 16-bit down-counter with an expire flag and synchronous active-low reset. A single instance serves both ACK and RUN.

Test Plan:
- Hold i_reset_n=0 for 3 cycles → o_start=0, o_pending=0, o_req_ready=1, o_err=0, o_done=0.
- Single i_req at cycle 0, peer MAX_AMOUNT=22 → o_start only in cycle 1; i_busy high cycles 2..22; o_done pulse in cycle 24; no o_err.
- i_req high cycles 0-4, MAX_PENDING=3 → requests in cycles 0-3 accepted; o_pending peaks at 3; o_req_ready=0 in cycle 4 and that request is ignored; 4 o_done pulses total; o_start at cycles 1, 25, 49, 73.
- Peer busy tied 0, single i_req at cycle 0 → o_start in cycle 1; o_err with code 01 within ACK_WAIT+1 cycles (cycle 4); o_pending=0; no o_done.
- Peer holds busy high 100 cycles after start → one o_err with code 10 after 32 RUN cycles; no o_start until busy falls; next queued job starts 1 cycle after busy falls.
- Two spurious-busy cases:
  - i_busy pulsed high for 5 cycles while IDLE with a request pending → one o_err with code 11; o_start withheld until the cycle after busy falls.
  - i_reset_n asserted mid-RUN → next cycle: IDLE, o_pending=0, no o_done.

Source files
------------

// File: rtl/busy_initiator_pkg.sv
// -----------------------------------------------------------------------------
// busy_initiator_pkg
//
// Purpose:
//   Definitions shared by the start/busy initiator and its wait timer. The
//   contents are the handshake state encodings, the fault codes reported on
//   o_err_code, the datapath widths, and a saturating-increment helper used by
//   the optional statistics counters.
//
// Ports:
//   None. This file is a package only.
// -----------------------------------------------------------------------------
package busy_initiator_pkg;

  // Handshake phases of the initiator.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,  // no job in flight, may issue a start
    StAck   = 2'd1,  // start issued, waiting for the peer to raise busy
    StRun   = 2'd2,  // peer busy, waiting for it to fall
    StDrain = 2'd3   // stuck-busy reported, waiting for busy to fall
  } busy_state_e;

  // Fault codes, valid while o_err is high.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NOACK = 2'b01;
  localparam logic [1:0] ERR_STUCK = 2'b10;
  localparam logic [1:0] ERR_SPUR  = 2'b11;

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned PEND_W  = 4;
  localparam int unsigned STAT_W  = 16;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    logic [STAT_W-1:0] res;
    res = (&val) ? val : val + STAT_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/busy_initiator_wait_timer.sv
// -----------------------------------------------------------------------------
// busy_initiator_wait_timer
//
// Purpose:
//   Loadable down-counter used by the initiator to bound both the
//   acknowledge window and the busy duration of a job. A load takes priority
//   over a decrement. The count stops at zero, and o_expired is high whenever
//   the count is zero.
//
// Ports:
//   i_clk       in   clock, posedge
//   i_reset_n   in   synchronous active-low reset, clears the count
//   i_load      in   load i_load_val on the next edge
//   i_load_val  in   value to load (TIMER_W bits)
//   i_dec       in   decrement on the next edge (ignored while zero)
//   o_expired   out  count is zero
// -----------------------------------------------------------------------------
module busy_initiator_wait_timer
  import busy_initiator_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_expired
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/busy_initiator.sv
// -----------------------------------------------------------------------------
// busy_initiator
//
// Purpose:
//   Initiator side of the start/busy handshake for fixed-duration busy
//   counters. The block queues job requests from upstream and issues one-cycle
//   start pulses to the peer. It follows each job's busy line to completion and
//   reports three protocol faults: the peer never acknowledges, busy stays high
//   too long, or busy rises while no job is in flight.
//
// Parameters:
//   MAX_PENDING  queued (not yet dispatched) requests allowed, 1..15
//   ACK_WAIT     cycles after o_start within which i_busy must rise, >= 1
//   MAX_WAIT     busy cycles allowed per job before a stuck fault, >= 2
//
// Ports:
//   i_clk        in   clock, posedge
//   i_reset_n    in   synchronous active-low reset
//   i_req        in   request one job, taken when i_req && o_req_ready
//   o_req_ready  out  queue has room (pending < MAX_PENDING)
//   o_start      out  one-cycle registered start pulse to the peer
//   i_busy       in   peer busy line
//   o_done       out  one-cycle pulse when a job completes
//   o_err        out  one-cycle pulse when a fault is detected
//   o_err_code   out  fault code, valid with o_err (01 no-ack, 10 stuck, 11 spurious)
//   o_pending    out  queued request count
//   o_done_cnt   out  saturating count of o_done pulses (0 unless stats built)
//   o_err_cnt    out  saturating count of o_err pulses (0 unless stats built)
//
// Build option:
//   Define BUSY_INITIATOR_STATS_EN to add the 16-bit saturating done/error
//   counters. When the option is not defined, both count ports are tied to
//   zero.
// -----------------------------------------------------------------------------
module busy_initiator
  import busy_initiator_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned ACK_WAIT    = 2,
  parameter int unsigned MAX_WAIT    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req,
  output logic              o_req_ready,
  output logic              o_start,
  input  logic              i_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [PEND_W-1:0] o_pending,
  output logic [STAT_W-1:0] o_done_cnt,
  output logic [STAT_W-1:0] o_err_cnt
);

  busy_state_e        r_state;
  logic [PEND_W-1:0]  r_pending;
  logic               r_start;
  logic               r_done;
  logic               r_err;
  logic [1:0]         r_err_code;
  // Set once a spurious busy has been reported in IDLE. It stays set until
  // busy falls, so each busy episode produces one report.
  logic               r_spur_seen;

  logic               w_req_ready;
  logic               w_accept;
  logic               w_have_work;
  logic               w_dispatch;
  logic               w_timer_load;
  logic [TIMER_W-1:0] w_timer_val;
  logic               w_timer_dec;
  logic               w_expired;

  // ---------------------------------------------------------------------------
  // Request queue and dispatch decision
  // ---------------------------------------------------------------------------
  assign w_req_ready = (r_pending < PEND_W'(MAX_PENDING));
  assign w_accept    = i_req && w_req_ready;
  // A request taken this cycle counts as work, so an idle queue still starts
  // on the very next cycle.
  assign w_have_work = (r_pending != '0) || w_accept;
  // DRAIN may start the next job as soon as busy falls. IDLE starts only while
  // busy is low.
  assign w_dispatch  = w_have_work && !i_busy &&
                       ((r_state == StIdle) || (r_state == StDrain));

  // ---------------------------------------------------------------------------
  // Shared wait timer: the acknowledge window and the run limit use one timer.
  // The timer loads ACK_WAIT on dispatch and MAX_WAIT-1 when busy first
  // appears. It then counts down in ACK while busy is low and in RUN while busy
  // is high. For the run limit, expiry therefore falls on the MAX_WAIT-th RUN
  // cycle.
  // ---------------------------------------------------------------------------
  assign w_timer_load = w_dispatch || ((r_state == StAck) && i_busy);
  assign w_timer_val  = w_dispatch ? TIMER_W'(ACK_WAIT) : TIMER_W'(MAX_WAIT - 1);
  assign w_timer_dec  = ((r_state == StAck) && !i_busy) ||
                        ((r_state == StRun) && i_busy);

  busy_initiator_wait_timer u_wait_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .i_dec      (w_timer_dec),
    .o_expired  (w_expired)
  );

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered pulse outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_pending   <= '0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_spur_seen <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;

      // Dispatch only happens when there is work, so this cannot underflow.
      // Accept is gated by o_req_ready, so it cannot overflow.
      r_pending <= r_pending + PEND_W'(w_accept) - PEND_W'(w_dispatch);

      if (!i_busy) begin
        r_spur_seen <= 1'b0;
      end else if (r_state == StIdle) begin
        r_spur_seen <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (i_busy) begin
            if (!r_spur_seen) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_SPUR;
            end
          end else if (w_dispatch) begin
            r_start <= 1'b1;
            r_state <= StAck;
          end
        end

        StAck: begin
          if (i_busy) begin
            r_state <= StRun;
          end else if (w_expired) begin
            // The peer never answered, so the job is dropped.
            r_err      <= 1'b1;
            r_err_code <= ERR_NOACK;
            r_state    <= StIdle;
          end
        end

        StRun: begin
          if (!i_busy) begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else if (w_expired) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_STUCK;
            r_state    <= StDrain;
          end
        end

        StDrain: begin
          // No timeout here. The faulted job gets no o_done.
          if (!i_busy) begin
            if (w_dispatch) begin
              r_start <= 1'b1;
              r_state <= StAck;
            end else begin
              r_state <= StIdle;
            end
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_start     = r_start;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_pending   = r_pending;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef BUSY_INITIATOR_STATS_EN
  logic [STAT_W-1:0] r_done_cnt;
  logic [STAT_W-1:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_done_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_done) begin
        r_done_cnt <= sat_inc(r_done_cnt);
      end
      if (r_err) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

  assign o_done_cnt = r_done_cnt;
  assign o_err_cnt  = r_err_cnt;
`else
  assign o_done_cnt = '0;
  assign o_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_busy_initiator.sv
// -----------------------------------------------------------------------------
// tb_busy_initiator
//
// Self-checking bench for busy_initiator. A behavioural model of the
// handshake is compared against the DUT outputs on every cycle. A set of
// directed scenarios checks event timing against hand-computed cycle
// numbers. A randomized phase follows, with random requests, peer durations,
// spurious busy pulses and resets.
// -----------------------------------------------------------------------------
module tb_busy_initiator;

  localparam int unsigned MAX_PENDING = 3;
  localparam int unsigned ACK_WAIT    = 2;
  localparam int unsigned MAX_WAIT    = 32;

  logic        i_clk     = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_req     = 1'b0;
  logic        i_busy;
  logic        o_req_ready;
  logic        o_start;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [3:0]  o_pending;
  logic [15:0] o_done_cnt;
  logic [15:0] o_err_cnt;

  // Peer model: a start seen in cycle N raises busy for peer_len cycles from
  // cycle N+1. A peer_len of 0 models a dead peer. force_busy injects
  // spurious busy.
  int   peer_left  = 0;
  int   peer_len   = 21;
  logic force_busy = 1'b0;

  assign i_busy = (peer_left > 0) || force_busy;

  always #5 i_clk = ~i_clk;

  busy_initiator #(
    .MAX_PENDING (MAX_PENDING),
    .ACK_WAIT    (ACK_WAIT),
    .MAX_WAIT    (MAX_WAIT)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_req),
    .o_req_ready (o_req_ready),
    .o_start     (o_start),
    .i_busy      (i_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_pending   (o_pending),
    .o_done_cnt  (o_done_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  // Event log, with cycle numbers relative to t0.
  int start_q[$];
  int done_q[$];
  int err_q[$];
  int code_q[$];
  int exp_q[$];
  int pend_at  [0:255];
  int ready_at [0:255];

  // Model state.
  int m_pend       = 0;
  bit m_wait_ack   = 1'b0;
  int m_ack_cycles = 0;
  bit m_running    = 1'b0;
  int m_run_cycles = 0;
  bit m_draining   = 1'b0;
  bit m_spur       = 1'b0;
  // Expected outputs for the current cycle.
  int e_start    = 0;
  int e_done     = 0;
  int e_err      = 0;
  int e_code     = 0;
  int e_pend     = 0;
  int e_done_cnt = 0;
  int e_err_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int act[$], input int exp[$]);
    chk({name, " count"}, act.size(), exp.size());
    for (int k = 0; k < act.size() && k < exp.size(); k++) begin
      chk($sformatf("%s[%0d]", name, k), act[k], exp[k]);
    end
  endtask

  // The model advances one cycle. It uses the inputs that the DUT samples at
  // the coming edge, and it produces the expected outputs for the next cycle.
  task automatic model_step();
    bit acc;
    bit disp;
    int ns, nd, ne, nc;
    if (!i_reset_n) begin
      m_pend = 0; m_wait_ack = 0; m_ack_cycles = 0; m_running = 0;
      m_run_cycles = 0; m_draining = 0; m_spur = 0;
      e_start = 0; e_done = 0; e_err = 0; e_code = 0; e_pend = 0;
      e_done_cnt = 0; e_err_cnt = 0;
    end else begin
`ifdef BUSY_INITIATOR_STATS_EN
      if (e_done != 0 && e_done_cnt < 65535) e_done_cnt++;
      if (e_err != 0 && e_err_cnt < 65535) e_err_cnt++;
`endif
      acc  = i_req && (m_pend < int'(MAX_PENDING));
      disp = 1'b0;
      ns = 0; nd = 0; ne = 0; nc = 0;
      if (m_wait_ack) begin
        m_ack_cycles++;
        if (i_busy) begin
          m_wait_ack = 0; m_running = 1; m_run_cycles = 0;
        end else if (m_ack_cycles > int'(ACK_WAIT)) begin
          ne = 1; nc = 1; m_wait_ack = 0;
        end
      end else if (m_running) begin
        if (!i_busy) begin
          nd = 1; m_running = 0;
        end else begin
          m_run_cycles++;
          if (m_run_cycles == int'(MAX_WAIT)) begin
            ne = 1; nc = 2; m_running = 0; m_draining = 1;
          end
        end
      end else if (i_busy) begin
        if (!m_draining && !m_spur) begin
          ne = 1; nc = 3; m_spur = 1;
        end
      end else begin
        m_draining = 0;
        if (m_pend > 0 || acc) begin
          ns = 1; disp = 1; m_wait_ack = 1; m_ack_cycles = 0;
        end
      end
      if (!i_busy) m_spur = 0;
      m_pend = m_pend + int'(acc) - int'(disp);
      e_start = ns; e_done = nd; e_err = ne; e_code = nc; e_pend = m_pend;
    end
  endtask

  // Compare, log, then advance the model. All of this runs at the negedge.
  initial begin
    int rel;
    forever begin
      @(negedge i_clk);
      cyc++;
      chk("start",     int'(o_start),     e_start);
      chk("done",      int'(o_done),      e_done);
      chk("err",       int'(o_err),       e_err);
      chk("err_code",  int'(o_err_code),  e_code);
      chk("pending",   int'(o_pending),   e_pend);
      chk("req_ready", int'(o_req_ready), (e_pend < int'(MAX_PENDING)) ? 1 : 0);
      chk("done_cnt",  int'(o_done_cnt),  e_done_cnt);
      chk("err_cnt",   int'(o_err_cnt),   e_err_cnt);
      rel = cyc - t0;
      if (o_start) start_q.push_back(rel);
      if (o_done)  done_q.push_back(rel);
      if (o_err) begin
        err_q.push_back(rel);
        code_q.push_back(int'(o_err_code));
      end
      if (rel >= 0 && rel < 256) begin
        pend_at[rel]  = int'(o_pending);
        ready_at[rel] = int'(o_req_ready);
      end
      model_step();
    end
  end

  // Peer: at each edge it reacts to the start and reset values that it sampled
  // in the cycle just ended.
  initial begin
    logic s;
    logic r;
    forever begin
      @(negedge i_clk);
      s = o_start;
      r = i_reset_n;
      @(posedge i_clk);
      #1;
      if (!r)                       peer_left = 0;
      else if (s && peer_len > 0)   peer_left = peer_len;
      else if (peer_left > 0)       peer_left = peer_left - 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Resets for two cycles and leaves the bench at the start of cycle 0.
  task automatic start_scen();
    i_req      = 1'b0;
    force_busy = 1'b0;
    i_reset_n  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    t0 = cyc + 1;
    start_q.delete(); done_q.delete(); err_q.delete(); code_q.delete();
    foreach (pend_at[k])  pend_at[k]  = -1;
    foreach (ready_at[k]) ready_at[k] = -1;
  endtask

  initial begin
    int pend_max;
    int fl;

    // Reset held for 3 cycles.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst start",     int'(o_start),     0);
    chk("rst pending",   int'(o_pending),   0);
    chk("rst req_ready", int'(o_req_ready), 1);
    chk("rst err",       int'(o_err),       0);
    chk("rst done",      int'(o_done),      0);

    // Single job with a 22-cycle peer.
    peer_len = 21;
    start_scen();
    i_req = 1'b1; step(1); i_req = 1'b0; step(40);
    exp_q = '{1};  chk_q("s2 start", start_q, exp_q);
    exp_q = '{24}; chk_q("s2 done",  done_q,  exp_q);
    exp_q.delete(); chk_q("s2 err", err_q, exp_q);

    // Requests in cycles 0-4 against a queue depth of 3.
    start_scen();
    i_req = 1'b1; step(5); i_req = 1'b0; step(110);
    exp_q = '{1, 25, 49, 73};  chk_q("s3 start", start_q, exp_q);
    exp_q = '{24, 48, 72, 96}; chk_q("s3 done",  done_q,  exp_q);
    exp_q.delete(); chk_q("s3 err", err_q, exp_q);
    chk("s3 ready c3", ready_at[3], 1);
    chk("s3 ready c4", ready_at[4], 0);
    chk("s3 pend c4",  pend_at[4],  3);
    pend_max = 0;
    foreach (pend_at[k]) if (pend_at[k] > pend_max) pend_max = pend_at[k];
    chk("s3 pend peak", pend_max, 3);

    // Dead peer: no acknowledge.
    peer_len = 0;
    start_scen();
    i_req = 1'b1; step(1); i_req = 1'b0; step(20);
    exp_q = '{1}; chk_q("s4 start", start_q, exp_q);
    exp_q = '{4}; chk_q("s4 err",   err_q,   exp_q);
    exp_q = '{1}; chk_q("s4 code",  code_q,  exp_q);
    exp_q.delete(); chk_q("s4 done", done_q, exp_q);
    chk("s4 pend c5", pend_at[5], 0);

    // Busy held for 100 cycles, with a second job queued behind the first.
    peer_len = 100;
    start_scen();
    i_req = 1'b1; step(2); i_req = 1'b0; step(48);
    peer_len = 21;
    step(100);
    exp_q = '{1, 103}; chk_q("s5 start", start_q, exp_q);
    exp_q = '{35};     chk_q("s5 err",   err_q,   exp_q);
    exp_q = '{2};      chk_q("s5 code",  code_q,  exp_q);
    exp_q = '{126};    chk_q("s5 done",  done_q,  exp_q);

    // Spurious busy for 5 cycles while a request is pending.
    peer_len = 21;
    start_scen();
    i_req = 1'b1; force_busy = 1'b1; step(1);
    i_req = 1'b0; step(4);
    force_busy = 1'b0; step(40);
    exp_q = '{1};  chk_q("s6a err",   err_q,   exp_q);
    exp_q = '{3};  chk_q("s6a code",  code_q,  exp_q);
    exp_q = '{6};  chk_q("s6a start", start_q, exp_q);
    exp_q = '{29}; chk_q("s6a done",  done_q,  exp_q);

    // Reset asserted in cycle 10, while the job is in RUN and two jobs are queued.
    start_scen();
    i_req = 1'b1; step(3); i_req = 1'b0; step(7);
    i_reset_n = 1'b0; step(1); i_reset_n = 1'b1; step(50);
    exp_q = '{1}; chk_q("s6b start", start_q, exp_q);
    exp_q.delete(); chk_q("s6b done", done_q, exp_q);
    exp_q.delete(); chk_q("s6b err",  err_q,  exp_q);
    chk("s6b pend c9",  pend_at[9],  2);
    chk("s6b pend c11", pend_at[11], 0);

    // Randomized traffic, checked cycle by cycle against the model.
    start_scen();
    fl = 0;
    for (int i = 0; i < 4000; i++) begin
      i_req = ($urandom_range(0, 99) < 35);
      if (fl > 0) fl--;
      else if ($urandom_range(0, 149) == 0) fl = $urandom_range(1, 6);
      force_busy = (fl > 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0:       peer_len = 0;
          1:       peer_len = $urandom_range(33, 45);
          2:       peer_len = 1;
          default: peer_len = $urandom_range(2, 25);
        endcase
      end
      i_reset_n = ($urandom_range(0, 399) != 0);
      step(1);
    end
    i_reset_n = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
